// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side adapter.
// Optional beat counter: FIFO_RD_CTRL_STATS_EN.
package fifo_pkg;

    localparam int FIFO_DWIDTH = 8;
    localparam int BEAT_CNT_W  = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_st_e;

    function automatic logic [1:0] st_occ(input buf_st_e st);
        return 2'(st);
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer; entry 0 is always the head and drives the stream.
// Registered head keeps m_data glitch-free and stable under back-pressure.
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int DWIDTH = FIFO_DWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              pop,
    output logic              valid,
    output logic [DWIDTH-1:0] head,
    output logic [1:0]        occ
);

    buf_st_e           st_q, st_d;
    logic [DWIDTH-1:0] ent0_q, ent0_d;
    logic [DWIDTH-1:0] ent1_q, ent1_d;

    always_comb begin
        st_d   = st_q;
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        unique case (st_q)
            EMPTY: begin
                if (push) begin
                    ent0_d = push_data;
                    st_d   = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    ent0_d = push_data;
                end else if (push) begin
                    ent1_d = push_data;
                    st_d   = TWO;
                end else if (pop) begin
                    st_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    ent0_d = ent1_q;
                    if (push) begin
                        ent1_d = push_data;
                    end else begin
                        st_d = ONE;
                    end
                end
            end
            default: st_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= EMPTY;
            ent0_q <= '0;
            ent1_q <= '0;
        end else begin
            st_q   <= st_d;
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
        end
    end

    assign valid = (st_q != EMPTY);
    assign head  = ent0_q;
    assign occ   = st_occ(st_q);

endmodule

// File: rtl/fifo_rd_ctrl.sv
// FIFO read adapter: credit-based read issue feeding a 2-entry skid buffer.
// Define FIFO_RD_CTRL_STATS_EN to add the accepted-beat counter port.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int DWIDTH = FIFO_DWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_data,
    output logic              fifo_rd,
    output logic              m_valid,
    output logic [DWIDTH-1:0] m_data,
    input  logic              m_ready
`ifdef FIFO_RD_CTRL_STATS_EN
    ,
    output logic [BEAT_CNT_W-1:0] beat_cnt
`endif
);

    logic       infl_q, infl_d;
    logic       pop;
    logic [1:0] occ;
    logic [2:0] used;

    assign pop = m_valid & m_ready;

    // Words held plus word arriving, minus the one leaving, must stay below 2.
    always_comb begin
        used    = {1'b0, occ} + {2'b0, infl_q};
        fifo_rd = !fifo_empty && !rst && (used < (3'd2 + {2'b0, pop}));
        infl_d  = fifo_rd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            infl_q <= 1'b0;
        end else begin
            infl_q <= infl_d;
        end
    end

    fifo_rd_skid #(
        .DWIDTH(DWIDTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (infl_q),
        .push_data(fifo_data),
        .pop      (pop),
        .valid    (m_valid),
        .head     (m_data),
        .occ      (occ)
    );

`ifdef FIFO_RD_CTRL_STATS_EN
    logic [BEAT_CNT_W-1:0] beat_q, beat_d;

    always_comb begin
        beat_d = beat_q + BEAT_CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

    assign beat_cnt = beat_q;
`endif

endmodule
